fetch_ctrl: RTL and testbench

Instruction-fetch controller that sequences the combinational instruction_mem (read_addr -> instruction, same-cycle). It owns the PC, drives the memory address and captures fetched words into a 2-entry prefetch buffer. The buffer feeds decode over a valid/ready handshake. It also handles branch/jump redirects and flags misaligned or out-of-range fetches as faults. It sits between instruction_mem and the decode stage.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_buf.sv | 64 ++++++
 rtl/fetch_ctrl.sv | 106 ++++++++++
 tb/tb_fetch_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller and its
// prefetch buffer.
package fetch_pkg;

  localparam int XLEN_W = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FAULT
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN_W-1:0] pc;
    logic [31:0]       instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Small synchronous FIFO holding fetched {pc, instr} pairs between the
// instruction memory and decode.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t mem_d [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q[AW-1:0]] = push_data;
        wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, fetches from a combinational
// instruction memory into a prefetch buffer, handles redirects and faults.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              IMEM_DEPTH = 64,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              BUF_DEPTH  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            fault,
  output logic [XLEN-1:0] fault_pc
);

  localparam logic [XLEN-1:0] PC_LIMIT = XLEN'(IMEM_DEPTH * INSTR_BYTES);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            fault_q, fault_d;
  logic [XLEN-1:0] fault_pc_q, fault_pc_d;

  logic         pc_legal, push, pop, buf_full, buf_empty;
  fetch_entry_t push_entry, head_entry;

  assign pc_legal = (pc_q[1:0] == 2'b00) && (pc_q < PC_LIMIT);
  assign pop      = out_valid && out_ready;
  assign push     = (state_q == RUN) && !redirect_valid && pc_legal &&
                    (!buf_full || pop);

  assign push_entry.pc    = pc_q;
  assign push_entry.instr = imem_rdata;

  fetch_buf #(
    .DEPTH(BUF_DEPTH)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect_valid),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .head     (head_entry),
    .full     (buf_full),
    .empty    (buf_empty)
  );

  assign imem_addr = pc_q;
  assign out_valid = !buf_empty;
  assign out_instr = buf_empty ? '0 : head_entry.instr;
  assign out_pc    = buf_empty ? '0 : head_entry.pc;
  assign fault     = fault_q;
  assign fault_pc  = fault_pc_q;

  // Redirect overrides everything, including a start in the same cycle.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    if (redirect_valid) begin
      state_d = RUN;
      pc_d    = redirect_pc;
      fault_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) state_d = RUN;
        RUN: begin
          if (!pc_legal) begin
            state_d    = FAULT;
            fault_d    = 1'b1;
            fault_pc_d = pc_q;
          end else if (push) begin
            pc_d = pc_q + XLEN'(INSTR_BYTES);
          end
        end
        default: state_d = FAULT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed stimulus queues expected
// deliveries, a negedge monitor compares every decode handshake.
module tb_fetch_ctrl;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;
  logic [31:0] fault_pc;

  logic [31:0] mem [64];
  exp_t        exp_q [$];
  int          checks = 0;
  int          errors = 0;

  fetch_ctrl #(
    .XLEN(32), .IMEM_DEPTH(64), .RESET_PC(32'h0), .BUF_DEPTH(2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .fault         (fault),
    .fault_pc      (fault_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    imem_rdata = 32'h0;
    if (imem_addr < 32'd256) imem_rdata = mem[imem_addr[7:2]];
  end

  function automatic logic [31:0] expInstr(input logic [31:0] pc);
    return 32'hC0DE_0000 | (pc >> 2);
  endfunction

  function automatic void expect_pc(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = expInstr(pc);
    exp_q.push_back(e);
  endfunction

  // Every accepted head must be the next expected delivery, in order.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (out_pc !== e.pc || out_instr !== e.instr) begin
        errors++;
        $display("[TB] FAIL delivery actual pc=%h instr=%h required pc=%h instr=%h",
                 out_pc, out_instr, e.pc, e.instr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic rv,
                               input logic [31:0] rpc, input logic rdy);
    start          = s;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    tick();
    start          = 1'b0;
    redirect_valid = 1'b0;
  endtask

  task automatic applyReset();
    start          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    exp_q.delete();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic waitDrain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 | i;
    rst_n          = 1'b0;
    start          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    #12;
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_fault", {31'b0, fault}, 32'd0);
    checkOutput("rst_fault_pc", fault_pc, 32'h0);
    checkOutput("rst_imem_addr", imem_addr, 32'h0);
    checkOutput("rst_out_pc", out_pc, 32'h0);
    checkOutput("rst_out_instr", out_instr, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("idle_no_fetch", imem_addr, 32'h0);

    // Streaming fetch at one instruction per cycle.
    for (int k = 0; k < 8; k++) expect_pc(32'(4 * k));
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("walk_addr_0", imem_addr, 32'h0);
    for (int k = 1; k < 8; k++) begin
      tick();
      checkOutput("walk_addr", imem_addr, 32'(4 * k));
    end
    waitDrain(10);

    // Decode stalled: buffer fills with PC 0 and 4, fetch stalls at 8.
    applyReset();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (4) tick();
    checkOutput("stall_addr", imem_addr, 32'h8);
    checkOutput("stall_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("stall_head_pc", out_pc, 32'h0);
    checkOutput("stall_head_instr", out_instr, expInstr(32'h0));
    for (int k = 0; k < 4; k++) expect_pc(32'(4 * k));
    out_ready = 1'b1;
    waitDrain(10);

    // Redirect flushes a full buffer.
    applyReset();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (3) tick();
    applyStimulus(1'b0, 1'b1, 32'h10, 1'b0);
    checkOutput("flush_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("flush_addr", imem_addr, 32'h10);
    expect_pc(32'h10);
    out_ready = 1'b1;
    waitDrain(5);

    // Misaligned redirect faults; a later redirect recovers.
    applyReset();
    applyStimulus(1'b0, 1'b1, 32'h2, 1'b0);
    checkOutput("mis_addr", imem_addr, 32'h2);
    checkOutput("mis_fault_early", {31'b0, fault}, 32'd0);
    tick();
    checkOutput("mis_fault", {31'b0, fault}, 32'd1);
    checkOutput("mis_fault_pc", fault_pc, 32'h2);
    tick();
    checkOutput("mis_addr_hold", imem_addr, 32'h2);
    checkOutput("mis_no_push", {31'b0, out_valid}, 32'd0);
    expect_pc(32'h0);
    expect_pc(32'h4);
    applyStimulus(1'b0, 1'b1, 32'h0, 1'b1);
    checkOutput("mis_fault_clr", {31'b0, fault}, 32'd0);
    waitDrain(6);

    // Out-of-range redirect, then sequential run into the top boundary.
    applyReset();
    applyStimulus(1'b0, 1'b1, 32'd1000, 1'b0);
    tick();
    checkOutput("far_fault", {31'b0, fault}, 32'd1);
    checkOutput("far_fault_pc", fault_pc, 32'd1000);
    for (int k = 0; k < 4; k++) expect_pc(32'(240 + 4 * k));
    applyStimulus(1'b0, 1'b1, 32'd240, 1'b1);
    checkOutput("edge_fault_clr", {31'b0, fault}, 32'd0);
    waitDrain(10);
    tick();
    tick();
    checkOutput("edge_fault", {31'b0, fault}, 32'd1);
    checkOutput("edge_fault_pc", fault_pc, 32'd256);
    checkOutput("edge_addr", imem_addr, 32'd256);
    checkOutput("edge_drained", {31'b0, out_valid}, 32'd0);

    // Asynchronous reset mid-run with a full buffer.
    applyReset();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (3) tick();
    checkOutput("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("async_fault", {31'b0, fault}, 32'd0);
    checkOutput("async_addr", imem_addr, 32'h0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    checkOutput("post_rst_addr", imem_addr, 32'h0);
    checkOutput("post_rst_valid", {31'b0, out_valid}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("restart_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("restart_pc", out_pc, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
